nco_iq_mixer: RTL
=================

# nco_iq_mixer

Parametrised successor to the 1-bit-input I/Q mixer in the 1-bit SDR front end. It adds an on-chip NCO (phase accumulator plus quarter-wave sine/cosine table), so the LO is generated internally instead of being driven from outside. It sign-mixes the 1-bit comparator sample against the LO, producing registered signed I/Q products for the downstream CIC decimators. It also returns the registered RF sample as the comparator feedback output.

## Interface
Parameters:
- LO_WIDTH, 8: signed width of the LO samples and of the mixer outputs.
- PHASE_WIDTH, 26: phase accumulator and tuning-word width.
- LUT_ADDR, 8: log2 of LO samples per cycle. The top LUT_ADDR bits of the phase address the table. Minimum value is 3.

Ports:
- clk, in, 1: system clock; all state is updated on its rising edge.
- reset, in, 1: asynchronous, active-high reset.
- rf_in, in, 1: 1-bit RF sample from the LVDS comparator.
- rf_out, out, 1: rf_in registered once; feedback to the comparator.
- enable, in, 1: advances the accumulator and qualifies the pipeline.
- ftw_in, in, PHASE_WIDTH: frequency tuning word, unsigned.
- ftw_load, in, 1: single-cycle strobe that captures ftw_in.
- phase_clear, in, 1: single-cycle strobe that zeroes the phase accumulator.
- mix_i, out, LO_WIDTH signed: rf-signed cosine product.
- mix_q, out, LO_WIDTH signed: rf-signed sine product.
- out_valid, out, 1: mix_i and mix_q carry a valid sample.

## Operation
Reset clears every register: ftw_reg, phase_acc, the pipeline, rf_out, mix_i, mix_q and out_valid are all 0.

Tuning word:
- ftw_load=1 writes ftw_in into ftw_reg at that edge.
- The accumulator add on that same edge still uses the old ftw_reg. The new word takes effect on the next enabled edge.

Accumulator, on each edge:
- phase_clear=1: phase_acc<=0. This takes priority over enable.
- Otherwise, enable=1: phase_acc<=(phase_acc+ftw_reg) mod 2^PHASE_WIDTH. Wrap-around is silent.
- Otherwise: phase_acc holds.

LO generation:
- Index idx = phase_acc[PHASE_WIDTH-1 -: LUT_ADDR], with N = 2^LUT_ADDR.
- sin = round(A·sin(2π·idx/N)) and cos = sin evaluated at (idx+N/4) mod N, where A = 2^(LO_WIDTH-1)-1.
- Quarter-wave table of N/4+1 entries, covering indices 0..N/4 inclusive. Symmetry logic selects the entry and the sign.
- Table values never reach −2^(LO_WIDTH-1).

Mixing:
- rf=1: mix = +LO. rf=0: mix = −LO.
- Negation saturates −2^(LO_WIDTH-1) to +A. This is defensive only; the table never produces that value.

Pipeline alignment:
- The rf sample is delayed to line up with the LO pipeline. The pair (rf_in, phase_acc) sampled at edge k produces mix_i/mix_q at edge k+3.
- out_valid is enable delayed by three edges.
- When enable=0 the pipeline keeps shifting, and mix_i/mix_q are don't-care while out_valid=0.

## Timing
- Latency: exactly 3 clk cycles from rf_in/phase to mix_i/mix_q. rf_out has a latency of 1.
- phase_clear at edge k: idx=0 is used at edge k+1, so mix_i=±A appears at k+4.
- ftw_load and phase_clear asserted together: both apply at that edge. The accumulator then advances from 0 using the new ftw from edge k+1.
- Reset mid-operation: all outputs go to 0 immediately, with no clock needed.
  - After reset deasserts, out_valid stays 0 until the third edge after enable is seen high.
  - ftw_reg=0 after reset, so the LO is DC (cos=A, sin=0) until a word is loaded.
- One sample per clk; no backpressure.

## Structure
- Package mixer_pkg holds:
  - default parameter values;
  - a constant function that builds the quarter-wave table for LO_WIDTH/LUT_ADDR;
  - the saturating-negate function.
- Sub-module nco_sincos_lut holds the registered quarter-wave lookup plus symmetry/sign logic. It produces sin and cos from idx with a 2-cycle latency.
- nco_iq_mixer top holds the accumulator, ftw register, rf delay line, mixer stage and valid pipe.

## Test plan
All scenarios use LO_WIDTH=8, PHASE_WIDTH=16, LUT_ADDR=8.
- Reset and load: hold reset → all outputs 0. Release, load ftw 0x4000, pulse phase_clear, hold rf_in=1 and enable=1 → from 4 cycles after the clear, mix_q cycles 0,127,0,−127 and mix_i cycles 127,0,−127,0.
- Sign flip: same as above with rf_in=0 → mix_i and mix_q are exactly negated. rf_out follows rf_in with 1-cycle delay.
- Slow tone: ftw 0x0100 → period of 256 samples. mix_q is 127 at idx 64 and −127 at idx 192, with no value outside ±127.
- Mid-stream retune: ftw_load of 0x8000 at edge k → phase steps by the old word at k and by 0x8000 from k+1 (checked against a reference model).
- Simultaneous strobes and gating: ftw_load+phase_clear in the same cycle → phase 0, then new word. Drop enable for 5 cycles → phase frozen, out_valid low for exactly 5 cycles, offset by 3.
- Reset mid-stream: assert reset between clock edges while streaming → outputs 0 at once. After release, out_valid returns on the third edge with enable high, and cos=127 and sin=0 until a word is loaded.

Source files
------------

// File: rtl/mixer_pkg.sv
// Shared defaults and constant helpers for the NCO I/Q mixer: quarter-wave
// sine table generation and saturating negation.
package mixer_pkg;

    localparam int unsigned LO_WIDTH_DEF    = 8;
    localparam int unsigned PHASE_WIDTH_DEF = 26;
    localparam int unsigned LUT_ADDR_DEF    = 8;

    // Quadrant of the LO phase: top two bits of the table index
    typedef enum logic [1:0] {
        QUAD_0,
        QUAD_1,
        QUAD_2,
        QUAD_3
    } quad_t;

    localparam longint      HALF_PI_Q30  = 64'sd1686629713;
    localparam int unsigned TAYLOR_TERMS = 10;

    // Entry k (0..N/4) of the quarter-wave table: round(A*sin(pi/2*k/(N/4))).
    // Integer Q30 Taylor series so elaboration needs no real arithmetic.
    function automatic int qw_entry(input int unsigned lo_width,
                                    input int unsigned lut_addr,
                                    input int unsigned k);
        int unsigned qn;
        longint      x;
        longint      x2;
        longint      term;
        longint      acc;
        longint      amp;
        longint      val;
        qn   = 32'd1 << (lut_addr - 32'd2);
        x    = (HALF_PI_Q30 * longint'(k)) / longint'(qn);
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int unsigned n = 1; n <= TAYLOR_TERMS; n++) begin
            term = (term * x2) >>> 30;
            term = -term / longint'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        amp = (64'sd1 <<< (lo_width - 1)) - 64'sd1;
        val = (acc * amp + (64'sd1 <<< 29)) >>> 30;
        if (val > amp) val = amp;
        if (val < 64'sd0) val = 64'sd0;
        return int'(val);
    endfunction

    // Negate a width-bit signed value, mapping the most negative code to +max
    function automatic int sat_neg(input int v, input int unsigned width);
        int lim;
        lim = int'(32'd1 << (width - 32'd1));
        return (v == -lim) ? lim - 1 : -v;
    endfunction

endpackage

// File: rtl/nco_sincos_lut.sv
// Registered quarter-wave sine/cosine lookup: quadrant folding, table read,
// then sign application. Two-cycle latency from idx to lo_sin/lo_cos.
module nco_sincos_lut
    import mixer_pkg::*;
#(
    parameter int unsigned LO_WIDTH = LO_WIDTH_DEF,
    parameter int unsigned LUT_ADDR = LUT_ADDR_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [LUT_ADDR-1:0]        idx,
    output logic signed [LO_WIDTH-1:0] lo_sin,
    output logic signed [LO_WIDTH-1:0] lo_cos
);

    localparam int unsigned OFS_W  = LUT_ADDR - 2;
    localparam int unsigned ADDR_W = LUT_ADDR - 1;
    localparam int unsigned QN     = 32'd1 << OFS_W;
    localparam logic [ADDR_W-1:0] QN_A = ADDR_W'(QN);

    logic signed [LO_WIDTH-1:0] rom [QN+1];

    for (genvar k = 0; k <= int'(QN); k++) begin : g_rom
        localparam int ENTRY = qw_entry(LO_WIDTH, LUT_ADDR, k);
        assign rom[k] = ENTRY[LO_WIDTH-1:0];
    end

    quad_t             quad;
    logic [ADDR_W-1:0] ofs;
    logic [ADDR_W-1:0] ofs_rev;
    logic [ADDR_W-1:0] sin_addr;
    logic [ADDR_W-1:0] cos_addr;
    logic              sin_neg;
    logic              cos_neg;

    // cos(idx) is sin(idx + N/4), so each quadrant reuses the same two addresses
    always_comb begin
        quad     = quad_t'(idx[LUT_ADDR-1 -: 2]);
        ofs      = {1'b0, idx[OFS_W-1:0]};
        ofs_rev  = QN_A - ofs;
        sin_addr = ofs;
        cos_addr = ofs_rev;
        sin_neg  = 1'b0;
        cos_neg  = 1'b0;
        unique case (quad)
            QUAD_0: begin
                sin_addr = ofs;
                cos_addr = ofs_rev;
            end
            QUAD_1: begin
                sin_addr = ofs_rev;
                cos_addr = ofs;
                cos_neg  = 1'b1;
            end
            QUAD_2: begin
                sin_addr = ofs;
                cos_addr = ofs_rev;
                sin_neg  = 1'b1;
                cos_neg  = 1'b1;
            end
            QUAD_3: begin
                sin_addr = ofs_rev;
                cos_addr = ofs;
                sin_neg  = 1'b1;
            end
        endcase
    end

    logic signed [LO_WIDTH-1:0] sin_mag;
    logic signed [LO_WIDTH-1:0] cos_mag;
    logic                       sin_neg_q;
    logic                       cos_neg_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sin_mag   <= '0;
            cos_mag   <= '0;
            sin_neg_q <= 1'b0;
            cos_neg_q <= 1'b0;
        end else begin
            sin_mag   <= rom[sin_addr];
            cos_mag   <= rom[cos_addr];
            sin_neg_q <= sin_neg;
            cos_neg_q <= cos_neg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lo_sin <= '0;
            lo_cos <= '0;
        end else begin
            lo_sin <= sin_neg_q ? LO_WIDTH'(sat_neg(int'(sin_mag), LO_WIDTH)) : sin_mag;
            lo_cos <= cos_neg_q ? LO_WIDTH'(sat_neg(int'(cos_mag), LO_WIDTH)) : cos_mag;
        end
    end

endmodule

// File: rtl/nco_iq_mixer.sv
// 1-bit RF I/Q mixer with on-chip NCO: phase accumulator, sin/cos LUT,
// rf-signed LO products and a matching valid pipe (3-cycle latency).
module nco_iq_mixer
    import mixer_pkg::*;
#(
    parameter int unsigned LO_WIDTH    = LO_WIDTH_DEF,
    parameter int unsigned PHASE_WIDTH = PHASE_WIDTH_DEF,
    parameter int unsigned LUT_ADDR    = LUT_ADDR_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rf_in,
    output logic                       rf_out,
    input  logic                       enable,
    input  logic [PHASE_WIDTH-1:0]     ftw_in,
    input  logic                       ftw_load,
    input  logic                       phase_clear,
    output logic signed [LO_WIDTH-1:0] mix_i,
    output logic signed [LO_WIDTH-1:0] mix_q,
    output logic                       out_valid
);

    logic [PHASE_WIDTH-1:0]     ftw_reg;
    logic [PHASE_WIDTH-1:0]     phase_acc;
    logic [LUT_ADDR-1:0]        idx;
    logic [1:0]                 rf_d;
    logic [2:0]                 en_d;
    logic signed [LO_WIDTH-1:0] lo_sin;
    logic signed [LO_WIDTH-1:0] lo_cos;

    // The add uses the pre-load ftw_reg; a new word applies from the next edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ftw_reg   <= '0;
            phase_acc <= '0;
        end else begin
            if (ftw_load) begin
                ftw_reg <= ftw_in;
            end
            if (phase_clear) begin
                phase_acc <= '0;
            end else if (enable) begin
                phase_acc <= phase_acc + ftw_reg;
            end
        end
    end

    // idx and rf_out sample together; rf_d/en_d track the two LUT stages
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            rf_out    <= 1'b0;
            rf_d      <= '0;
            en_d      <= '0;
            out_valid <= 1'b0;
        end else begin
            idx       <= phase_acc[PHASE_WIDTH-1 -: LUT_ADDR];
            rf_out    <= rf_in;
            rf_d      <= {rf_d[0], rf_out};
            en_d      <= {en_d[1:0], enable};
            out_valid <= en_d[2];
        end
    end

    nco_sincos_lut #(
        .LO_WIDTH (LO_WIDTH),
        .LUT_ADDR (LUT_ADDR)
    ) u_lut (
        .clk    (clk),
        .reset  (reset),
        .idx    (idx),
        .lo_sin (lo_sin),
        .lo_cos (lo_cos)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mix_i <= '0;
            mix_q <= '0;
        end else begin
            mix_i <= rf_d[1] ? lo_cos : LO_WIDTH'(sat_neg(int'(lo_cos), LO_WIDTH));
            mix_q <= rf_d[1] ? lo_sin : LO_WIDTH'(sat_neg(int'(lo_sin), LO_WIDTH));
        end
    end

endmodule
